// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and result-status bundle
// for the ALU execute stage.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_ADC = 3'd2;
    localparam logic [2:0] ALU_SBB = 3'd3;
    localparam logic [2:0] ALU_CMP = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_CLC = 3'd6;
    localparam logic [2:0] ALU_STC = 3'd7;

    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    typedef struct packed {
        logic [3:0] flags;
        logic       gt;
        logic       lt;
        logic       eq;
    } alu_stat_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle of the ALU
// execute stage; master drives operations, slave is the stage.
interface alu_exec_stage_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_res;
    logic [3:0]            out_flags;
    logic                  out_gt;
    logic                  out_lt;
    logic                  out_eq;
    logic                  carry_q;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags,
        input  out_gt, out_lt, out_eq, carry_q
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags,
        output out_gt, out_lt, out_eq, carry_q
    );
endinterface

// File: rtl/alu_exec_stage_carry_lookahead.sv
// Adder/subtractor built from 4-bit lookahead groups, plus signed
// compare of the raw operands. DATA_WIDTH must be a multiple of 4.
module carry_lookahead #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  add_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  cin_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  cout_o,
    output logic                  gt_o,
    output logic                  lt_o,
    output logic                  eq_o
);
    localparam int NG = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] bx;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] p;
    logic [DATA_WIDTH-1:0] c;
    logic [NG-1:0]         gg;
    logic [NG-1:0]         pg;

    always_comb begin
        bx = add_op_i ? b_i : ~b_i;
        g  = a_i & bx;
        p  = a_i ^ bx;
    end

    always_comb begin
        logic cy;
        cy = cin_i;
        c  = '0;
        gg = '0;
        pg = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (&p[4*j+2 +: 2] & g[4*j+1])
                  | (&p[4*j+1 +: 3] & g[4*j]);
            pg[j] = &p[4*j +: 4];
            c[4*j]   = cy;
            c[4*j+1] = g[4*j] | (p[4*j] & cy);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (&p[4*j +: 2] & cy);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (&p[4*j+1 +: 2] & g[4*j])
                     | (&p[4*j +: 3] & cy);
            cy = gg[j] | (pg[j] & cy);
        end
        cout_o = cy;
    end

    assign sum_o = p ^ c;
    assign eq_o  = (a_i == b_i);
    assign lt_o  = $signed(a_i) < $signed(b_i);
    assign gt_o  = !lt_o && !eq_o;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with architectural carry flag.
// Define ALU_EXEC_SKID_EN to add a 1-entry skid register.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input logic             clk,
    input logic             reset,
    alu_exec_stage_if.slave io
);
    localparam int MSB = DATA_WIDTH - 1;

    logic                  accept;
    logic                  sub_op;
    logic                  cin;
    logic [DATA_WIDTH-1:0] sum;
    logic                  cout;
    logic                  gt;
    logic                  lt;
    logic                  eq;
    logic [DATA_WIDTH-1:0] op_res;
    alu_stat_t             op_stat;
    logic                  op_cf;
    logic                  cf_q, cf_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    alu_stat_t             stat_q, stat_d;

    assign accept = io.in_valid && io.in_ready;

    always_comb begin
        sub_op = 1'b0;
        cin    = 1'b0;
        unique case (io.in_op)
            ALU_SUB, ALU_CMP, ALU_SLT: begin
                sub_op = 1'b1;
                cin    = 1'b1;
            end
            ALU_ADC: cin = cf_q;
            ALU_SBB: begin
                sub_op = 1'b1;
                cin    = cf_q;
            end
            default: ;
        endcase
    end

    carry_lookahead #(.DATA_WIDTH(DATA_WIDTH)) u_cla (
        .add_op_i (!sub_op),
        .a_i      (io.in_a),
        .b_i      (io.in_b),
        .cin_i    (cin),
        .sum_o    (sum),
        .cout_o   (cout),
        .gt_o     (gt),
        .lt_o     (lt),
        .eq_o     (eq)
    );

    always_comb begin
        op_res  = sum;
        op_cf   = cout;
        op_stat = '0;
        op_stat.flags[FLG_N] = sum[MSB];
        op_stat.flags[FLG_Z] = (sum == '0);
        op_stat.flags[FLG_C] = cout;
        op_stat.flags[FLG_V] = (sum[MSB] != io.in_a[MSB]) &&
            (sub_op ? (io.in_a[MSB] != io.in_b[MSB])
                    : (io.in_a[MSB] == io.in_b[MSB]));
        op_stat.gt = gt;
        op_stat.lt = lt;
        op_stat.eq = eq;
        unique case (io.in_op)
            ALU_CMP: op_res = '0;
            ALU_SLT: begin
                op_res = {{(DATA_WIDTH-1){1'b0}}, lt};
                op_cf  = cf_q;
            end
            ALU_CLC, ALU_STC: begin
                op_res  = '0;
                op_cf   = (io.in_op == ALU_STC);
                op_stat = '0;
                op_stat.flags[FLG_Z] = 1'b1;
                op_stat.flags[FLG_C] = op_cf;
            end
            default: ;
        endcase
    end

    assign cf_d = accept ? op_cf : cf_q;

`ifdef ALU_EXEC_SKID_EN
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] skid_res_q, skid_res_d;
    alu_stat_t             skid_stat_q, skid_stat_d;

    assign io.in_ready = in_ready_q;

    // An op accepted while stalled parks in the skid entry and
    // drains ahead of any newer op, keeping result order.
    always_comb begin
        out_valid_d  = out_valid_q;
        res_d        = res_q;
        stat_d       = stat_q;
        skid_valid_d = skid_valid_q;
        skid_res_d   = skid_res_q;
        skid_stat_d  = skid_stat_q;
        if (!out_valid_q || io.out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                res_d        = skid_res_q;
                stat_d       = skid_stat_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    res_d  = op_res;
                    stat_d = op_stat;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_res_d   = op_res;
            skid_stat_d  = op_stat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            skid_res_q   <= '0;
            skid_stat_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            skid_res_q   <= skid_res_d;
            skid_stat_q  <= skid_stat_d;
        end
    end
`else
    assign io.in_ready = !out_valid_q || io.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        stat_d      = stat_q;
        if (!out_valid_q || io.out_ready) begin
            out_valid_d = accept;
            if (accept) begin
                res_d  = op_res;
                stat_d = op_stat;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            stat_q      <= '0;
            cf_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            stat_q      <= stat_d;
            cf_q        <= cf_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_res   = res_q;
    assign io.out_flags = stat_q.flags;
    assign io.out_gt    = stat_q.gt;
    assign io.out_lt    = stat_q.lt;
    assign io.out_eq    = stat_q.eq;
    assign io.carry_q   = cf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table, stall/reset sequences
// and a randomized backpressure run against a reference model.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flags;
        logic        gt;
        logic        lt;
        logic        eq;
        logic        cy;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    initial forever #5 clk = ~clk;

    alu_exec_stage_if #(.DATA_WIDTH(64)) io ();

    alu_exec_stage #(.DATA_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    exp_t q[$];
    exp_t cur_exp;
    exp_t cy_exp;
    logic cy_pend = 1'b0;
    logic mcarry = 1'b0;
    logic bp_en = 1'b0;
    vec_t tbl[14];

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] res,
                                input logic [3:0] fl,
                                input logic gt, input logic lt,
                                input logic eq, input logic cy);
        exp_t e;
        e.res = res; e.flags = fl;
        e.gt = gt; e.lt = lt; e.eq = eq; e.cy = cy;
        return e;
    endfunction

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b,
                                   input logic c);
        exp_t        e;
        logic [64:0] s;
        logic        sub, ci;
        logic [63:0] bx;
        sub = (op == ALU_SUB) || (op == ALU_SBB) ||
              (op == ALU_CMP) || (op == ALU_SLT);
        ci  = (op == ALU_ADC || op == ALU_SBB) ? c : sub;
        bx  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bx} + {64'd0, ci};
        e.flags = {s[63], s[63:0] == 64'd0, s[64],
                   (s[63] != a[63]) &&
                   (sub ? a[63] != b[63] : a[63] == b[63])};
        e.lt  = $signed(a) < $signed(b);
        e.gt  = $signed(a) > $signed(b);
        e.eq  = a == b;
        e.res = s[63:0];
        e.cy  = s[64];
        if (op == ALU_CMP) e.res = '0;
        if (op == ALU_SLT) begin
            e.res = {63'd0, e.lt};
            e.cy  = c;
        end
        if (op == ALU_CLC || op == ALU_STC) begin
            e.cy    = (op == ALU_STC);
            e.res   = '0;
            e.flags = {1'b0, 1'b1, e.cy, 1'b0};
            e.gt = 0; e.lt = 0; e.eq = 0;
        end
        return e;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return ONES;
            2: return MAXP;
            3: return MINN;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Handshakes are decided at the next rising edge; look at them
    // half a cycle earlier while everything is stable.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (cy_pend) begin
            check("carry_q", 128'(io.carry_q), 128'(cy_exp.cy));
            cy_pend = 1'b0;
        end
        if (reset) begin
            q.delete();
            mcarry = 1'b0;
        end else begin
            if (io.out_valid && io.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 128'(io.out_valid), 128'(0));
                end else begin
                    e = q.pop_front();
                    check("result",
                        128'({io.out_res, io.out_flags,
                              io.out_gt, io.out_lt, io.out_eq}),
                        128'({e.res, e.flags, e.gt, e.lt, e.eq}));
                end
            end
            if (io.in_valid && io.in_ready) begin
                q.push_back(cur_exp);
                mcarry  = cur_exp.cy;
                cy_exp  = cur_exp;
                cy_pend = 1'b1;
                acc_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) io.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input exp_t e);
        logic acc;
        int   n;
        io.in_valid = 1'b1;
        io.in_op    = op;
        io.in_a     = a;
        io.in_b     = b;
        cur_exp     = e;
        n   = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = io.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        check("accept", 128'(acc), 128'(1));
    endtask

    task automatic idle();
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t ex, ey, ez, ew;
        int   a0;
        io.in_valid = 0; io.in_op = 0; io.in_a = 0; io.in_b = 0;
        io.out_ready = 1; cur_exp = '0;

        tbl[0]  = '{ALU_ADD, 64'd5, 64'd7, mk(64'd12, 4'b0000, 0, 1, 0, 0)};
        tbl[1]  = '{ALU_SUB, 64'd3, 64'd3, mk(64'd0, 4'b0110, 0, 0, 1, 1)};
        tbl[2]  = '{ALU_CMP, ONES, 64'd1, mk(64'd0, 4'b1010, 0, 1, 0, 1)};
        tbl[3]  = '{ALU_ADD, ONES, 64'd1, mk(64'd0, 4'b0110, 0, 1, 0, 1)};
        tbl[4]  = '{ALU_ADC, 64'd0, 64'd0, mk(64'd1, 4'b0000, 0, 0, 1, 0)};
        tbl[5]  = '{ALU_ADD, MAXP, 64'd1, mk(MINN, 4'b1001, 1, 0, 0, 0)};
        tbl[6]  = '{ALU_SUB, MINN, 64'd1, mk(MAXP, 4'b0011, 0, 1, 0, 1)};
        tbl[7]  = '{ALU_SLT, M5, 64'd3, mk(64'd1, 4'b1010, 0, 1, 0, 1)};
        tbl[8]  = '{ALU_CLC, 64'h5555, 64'hAAAA,
                    mk(64'd0, 4'b0100, 0, 0, 0, 0)};
        tbl[9]  = '{ALU_SBB, 64'd10, 64'd3, mk(64'd6, 4'b0010, 1, 0, 0, 1)};
        tbl[10] = '{ALU_STC, 64'd9, 64'd9, mk(64'd0, 4'b0110, 0, 0, 0, 1)};
        tbl[11] = '{ALU_ADC, 64'd0, 64'd0, mk(64'd1, 4'b0000, 0, 0, 1, 0)};
        tbl[12] = '{ALU_SBB, 64'd0, 64'd0, mk(ONES, 4'b1000, 0, 0, 1, 0)};
        tbl[13] = '{ALU_SLT, 64'd3, M5, mk(64'd0, 4'b0000, 1, 0, 0, 0)};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(io.out_valid), 128'(0));
        check("rst_outputs", 128'({io.out_res, io.out_flags,
              io.out_gt, io.out_lt, io.out_eq}), 128'(0));
        check("rst_carry", 128'(io.carry_q), 128'(0));
        check("rst_in_ready", 128'(io.in_ready), 128'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
        idle();
        idle();

        ex = mk(64'd123, 4'b0000, 1, 0, 0, 0);
        ey = mk(64'd2, 4'b0000, 0, 0, 1, 0);
        io.out_ready = 1'b0;
        send(ALU_ADD, 64'd100, 64'd23, ex);
        io.in_a = 64'd1; io.in_b = 64'd1; cur_exp = ey;
        a0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 128'(io.out_valid), 128'(1));
            check("stall_hold", 128'({io.out_res, io.out_flags,
                  io.out_gt, io.out_lt, io.out_eq}),
                  128'({ex.res, ex.flags, ex.gt, ex.lt, ex.eq}));
`ifdef ALU_EXEC_SKID_EN
            check("stall_in_ready", 128'(io.in_ready), 128'(i == 0));
`else
            check("stall_in_ready", 128'(io.in_ready), 128'(0));
`endif
            @(posedge clk);
            #1;
            if (acc_cnt != a0) io.in_valid = 1'b0;
        end
`ifdef ALU_EXEC_SKID_EN
        check("stall_accepts", 128'(acc_cnt - a0), 128'(1));
`else
        check("stall_accepts", 128'(acc_cnt - a0), 128'(0));
`endif
        io.out_ready = 1'b1;
        if (acc_cnt == a0) send(ALU_ADD, 64'd1, 64'd1, ey);
        repeat (4) idle();

        ez = mk(64'd0, 4'b0110, 0, 1, 0, 1);
        ew = mk(64'd0, 4'b0110, 0, 0, 0, 1);
        io.out_ready = 1'b0;
        send(ALU_ADD, ONES, 64'd1, ez);
        io.in_op = ALU_STC; cur_exp = ew;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall_valid", 128'(io.out_valid), 128'(0));
        check("rst_stall_carry", 128'(io.carry_q), 128'(0));
        check("rst_stall_ready", 128'(io.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        check("rst_skid_gone", 128'(io.out_valid), 128'(0));
        @(posedge clk);
        #1 io.out_ready = 1'b1;

        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [63:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            send(op, a, b, model(op, a, b, mcarry));
        end
        io.in_valid = 1'b0;
        bp_en = 1'b0;
        io.out_ready = 1'b1;
        repeat (5) idle();
        check("drain", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered ALU execute stage that accepts decoded ALU operations over a valid/ready handshake and drives the 64-bit `carry_lookahead` adder/comparator. It captures the sum, carry, signed flags and comparison results into an output register. It keeps an architectural carry flag so that multi-word add/subtract chains work across operations. It sits between the operand-fetch/issue logic and the writeback/branch-resolve logic.

## Interface
Parameters:
- `DATA_WIDTH`, 64, operand and result width; passed to `carry_lookahead`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: an operation is presented.
- `in_ready`, out, 1: the stage can accept an operation this cycle.
- `in_op`, in, 3: opcode (see Operation).
- `in_a`, in, DATA_WIDTH: operand A, signed.
- `in_b`, in, DATA_WIDTH: operand B, signed.
- `out_valid`, out, 1: the output register holds a result.
- `out_ready`, in, 1: the consumer takes the result this cycle.
- `out_res`, out, DATA_WIDTH: result.
- `out_flags`, out, 4: `{N,Z,C,V}`.
- `out_gt`, out, 1: signed A>B.
- `out_lt`, out, 1: signed A<B.
- `out_eq`, out, 1: A==B.
- `carry_q`, out, 1: the architectural carry flag.

## Operation
- An operation is accepted when `in_valid && in_ready`.
- Adder drive rules:
  - Add ops drive `add_op_i=1`, giving res = A+B+cin.
  - Subtract ops drive `add_op_i=0`, giving res = A+~B+cin.
  - `cout` is carry-out. For subtract, cout=1 means no borrow.
- Opcodes:
  - 0 ADD: cin=0.
  - 1 SUB: cin=1.
  - 2 ADC: add, cin=`carry_q`.
  - 3 SBB: subtract, cin=`carry_q`.
  - 4 CMP: subtract, cin=1. Flags and compare outputs are produced; `out_res`=0.
  - 5 SLT: subtract, cin=1. `out_res`={0…,lt}.
  - 6 CLC: `out_res`=0.
  - 7 STC: `out_res`=0.
- Carry flag update, on the same edge the op is accepted:
  - ops 0–4 load cout;
  - op 5 holds;
  - op 6 clears;
  - op 7 sets.
  - The next accepted op sees the updated value, including back-to-back ADC chains.
- Flags are computed from the adder result, before CMP/SLT masking:
  - Z = (sum==0).
  - N = sum[MSB].
  - C = cout.
  - V for add: A[MSB]==B[MSB] and sum[MSB]!=A[MSB].
  - V for subtract: A[MSB]!=B[MSB] and sum[MSB]!=A[MSB].
  - For ops 6/7: flags = {0,1,new C,0}; gt/lt/eq = 0.
- gt/lt/eq are taken from the adder's signed comparison outputs for ops 0–5.
- Output register hold rule: the output register holds while `out_valid && !out_ready`. Its contents must not change while stalled.

## Timing
- Latency is 1 cycle. An op accepted at edge k produces `out_valid`=1 after edge k.
- Throughput is 1 op/cycle when `out_ready`=1.
- Reset values: `out_valid`=0, `carry_q`=0, `out_res`=0, `out_flags`=0, `out_gt`/`lt`/`eq`=0. `in_ready` is 1 after reset.
- Without the skid buffer: `in_ready` = !`out_valid` || `out_ready`, which is combinational.
- Simultaneous accept and output-consume in the same cycle: the output register loads the new op, and `out_valid` stays 1.
- Reset mid-stall discards the held result and any skid entry, and clears `carry_q`.
- Operand values are don't-care when `in_valid`=0. `carry_q` must not change in that case.

## Configuration
- `ALU_EXEC_SKID_EN` defined:
  - A 1-entry skid register is added.
  - `in_ready` becomes a flop: `in_ready` = skid empty.
  - An op accepted while the output is stalled is captured into the skid register. It moves to the output on the next `out_ready` cycle.
  - Result order and carry order are preserved.
  - Reset clears the skid valid bit.
- `ALU_EXEC_SKID_EN` undefined: no skid register; the combinational `in_ready` above applies.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `ALU_ADD`…`ALU_STC`;
  - flag bit indices `FLG_N`, `FLG_Z`, `FLG_C`, `FLG_V`.
- Sub-module: one instance of `carry_lookahead` (`DATA_WIDTH` passed through). Decode, carry register, output register and skid register are local to this block.

## Test plan
- Reset, then ADD 5+7 → after 1 cycle: `out_res`=12, flags {0,0,0,0}, `carry_q`=0, `lt`=1.
- SUB 3−3 → `out_res`=0, Z=1, C=1, eq=1.
- CMP −1 vs 1 → `out_res`=0, N=1, lt=1.
- 128-bit chain:
  - ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1 → `out_res`=0, C=1.
  - Back-to-back ADC A=0, B=0 → `out_res`=1, `carry_q`=0.
- Overflow: ADD 0x7FFF_FFFF_FFFF_FFFF+1 → V=1, N=1.
- Overflow: SUB 0x8000_0000_0000_0000−1 → V=1.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1:
  - Output stays stable.
  - Without skid: `in_ready`=0 while stalled.
  - With skid: exactly one extra op is accepted, then `in_ready`=0.
  - After release, results appear in order.
- Assert reset during a stall → next cycle `out_valid`=0, `carry_q`=0.
- STC then ADC 0+0 → `out_res`=1.
